// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer issuing control to the 8-bit ALU datapath.
// Runs from PC 0 on start until the HALT encoding is decoded, counting the active cycles.
module fetch_decode_ctrl #(
   parameter int         PC_W       = 8,
   parameter logic [8:0] HALT_INSTR = 9'h1FF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic [PC_W-1:0] instrAddr,
   input  logic [8:0]      instr,
   output logic [2:0]      aluOp,
   output logic [2:0]      regA,
   output logic [2:0]      regB,
   output logic            regWrite,
   output logic            memRead,
   output logic            memWrite,
   input  logic            jumpFlag,
   output logic [2:0]      lutIndex,
   input  logic [PC_W-1:0] lutTarget,
   output logic            done,
   output logic [15:0]     cycleCount
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_LDWB   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   localparam logic [2:0] OP_LD   = 3'd5;
   localparam logic [2:0] OP_ST   = 3'd6;
   localparam logic [2:0] OP_BLQZ = 3'd7;

   state_t          state_r, state_s;
   logic [PC_W-1:0] pc_r, pc_s, pc_inc_s;
   logic [8:0]      ir_r, ir_s;
   logic [15:0]     cnt_r, cnt_s;

   assign pc_inc_s   = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
   assign instrAddr  = pc_r;
   assign cycleCount = cnt_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
         pc_r    <= '0;
         ir_r    <= 9'd0;
         cnt_r   <= 16'd0;
      end else begin
         state_r <= state_s;
         pc_r    <= pc_s;
         ir_r    <= ir_s;
         cnt_r   <= cnt_s;
      end
   end

   // Next-state, PC, IR and saturating cycle counter
   always_comb begin
      state_s = state_r;
      pc_s    = pc_r;
      ir_s    = ir_r;
      cnt_s   = cnt_r;
      if (state_r inside {S_FETCH, S_DECODE, S_EXEC, S_LDWB}) begin
         if (cnt_r != 16'hFFFF) begin
            cnt_s = cnt_r + 16'd1;
         end else begin
            cnt_s = cnt_r;
         end
      end else begin
         cnt_s = cnt_r;
      end
      case (state_r)
         S_IDLE, S_DONE: begin
            if (start) begin
               pc_s    = '0;
               cnt_s   = 16'd0;
               state_s = S_FETCH;
            end else begin
               state_s = state_r;
            end
         end
         S_FETCH:  state_s = S_DECODE;
         S_DECODE: begin
            ir_s = instr;
            if (instr == HALT_INSTR) begin
               state_s = S_DONE;
            end else begin
               state_s = S_EXEC;
            end
         end
         S_EXEC: begin
            case (ir_r[8:6])
               OP_LD:   state_s = S_LDWB;
               OP_BLQZ: begin
                  pc_s    = jumpFlag ? lutTarget : pc_inc_s;
                  state_s = S_FETCH;
               end
               default: begin
                  pc_s    = pc_inc_s;
                  state_s = S_FETCH;
               end
            endcase
         end
         S_LDWB: begin
            pc_s    = pc_inc_s;
            state_s = S_FETCH;
         end
         default: state_s = S_IDLE;
      endcase
   end

   // Datapath control decoded from IR; forced quiet while reset is asserted
   always_comb begin
      aluOp    = 3'd0;
      regA     = 3'd0;
      regB     = 3'd0;
      lutIndex = 3'd0;
      regWrite = 1'b0;
      memRead  = 1'b0;
      memWrite = 1'b0;
      done     = 1'b0;
      if (!reset && (state_r == S_EXEC || state_r == S_LDWB)) begin
         aluOp    = ir_r[8:6];
         regA     = ir_r[5:3];
         regB     = ir_r[2:0];
         lutIndex = ir_r[2:0];
         if (state_r == S_LDWB) begin
            regWrite = 1'b1;
         end else begin
            case (ir_r[8:6])
               OP_LD:   memRead  = 1'b1;
               OP_ST:   memWrite = 1'b1;
               OP_BLQZ: regWrite = 1'b0;
               default: regWrite = 1'b1;
            endcase
         end
      end else begin
         done = !reset && (state_r == S_DONE);
      end
   end

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Scoreboard bench: an instruction-level program model predicts every control event and halt.
module tb_fetch_decode_ctrl;
   localparam logic [8:0] HALT = 9'h1FF;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic [7:0] instrAddr, lutTarget;
   logic [8:0] instr;
   logic [2:0] aluOp, regA, regB, lutIndex;
   logic regWrite, memRead, memWrite, jumpFlag, done;
   logic [15:0] cycleCount;

   logic [8:0] imem [256];
   logic [7:0] lut_tab [8];
   logic       jf_tab [8];
   logic       noise;
   logic [7:0] noise_b;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;
   logic       done_q = 1'b0;

   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] at;
      logic [7:0]  pc;
      logic [2:0]  op, ra, rb, li;
      logic        rw, mr, mw;
      logic [15:0] cc;
   } ev_t;
   ev_t exp_q [$];

   fetch_decode_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .instrAddr(instrAddr), .instr(instr),
      .aluOp(aluOp), .regA(regA), .regB(regB), .regWrite(regWrite), .memRead(memRead),
      .memWrite(memWrite), .jumpFlag(jumpFlag), .lutIndex(lutIndex), .lutTarget(lutTarget),
      .done(done), .cycleCount(cycleCount)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      instr   <= imem[instrAddr];
      noise   <= 1'($urandom_range(0, 1));
      noise_b <= 8'($urandom_range(0, 255));
   end

   // ALU flag and LUT: meaningful only for a BLQZ in execute, noise otherwise
   assign jumpFlag  = (aluOp == 3'd7) ? jf_tab[lutIndex] : noise;
   assign lutTarget = (aluOp == 3'd7) ? lut_tab[lutIndex] : noise_b;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic compare_ev(input string nm, input ev_t act);
      ev_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s_unexpected: got %h expected no event", nm, act);
      end else begin
         e = exp_q.pop_front();
         if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, e);
         end
      end
   endtask

   // Monitor: every execute/write-back cycle and every rising done is one event
   always @(negedge clk) begin
      if (!reset) begin
         if (regWrite || memRead || memWrite || aluOp == 3'd7)
            compare_ev("ctrl", {2'd0, 32'(cyc), instrAddr, aluOp, regA, regB, lutIndex,
                                regWrite, memRead, memWrite, 16'd0});
         if (done && !done_q)
            compare_ev("halt", {2'd1, 32'(cyc), instrAddr, aluOp, regA, regB, lutIndex,
                                regWrite, memRead, memWrite, cycleCount});
      end
      done_q <= done;
   end

   task automatic push_ctrl(input int at, input logic [7:0] pc, input logic [8:0] ins,
                            input logic rw, input logic mr, input logic mw);
      ev_t e;
      e = '{kind: 2'd0, at: 32'(at), pc: pc, op: ins[8:6], ra: ins[5:3], rb: ins[2:0],
            li: ins[2:0], rw: rw, mr: mr, mw: mw, cc: 16'd0};
      exp_q.push_back(e);
   endtask

   task automatic push_done(input int at, input logic [7:0] pc, input logic [15:0] cc);
      ev_t e;
      e = '{kind: 2'd1, at: 32'(at), pc: pc, op: 3'd0, ra: 3'd0, rb: 3'd0, li: 3'd0,
            rw: 1'b0, mr: 1'b0, mw: 1'b0, cc: cc};
      exp_q.push_back(e);
   endtask

   // Instruction-level model: 3 cycles per instruction, 4 for LD, halt seen 3 cycles after its fetch slot
   task automatic run_model(input int sc, input int max_n, output int t, output bit halted);
      logic [7:0] pc;
      logic [8:0] ins;
      logic [2:0] op;
      int n;
      pc = 8'd0; t = 0; halted = 1'b0; n = 0;
      while (!halted && n < max_n) begin
         ins = imem[pc];
         op  = ins[8:6];
         if (ins == HALT) begin
            push_done(sc + t + 3, pc, 16'(t + 2));
            halted = 1'b1;
         end else begin
            push_ctrl(sc + t + 3, pc, ins, op < 3'd5, op == 3'd5, op == 3'd6);
            if (op == 3'd5) begin
               push_ctrl(sc + t + 4, pc, ins, 1'b1, 1'b0, 1'b0);
               t += 4;
            end else begin
               t += 3;
            end
            if (op == 3'd7 && jf_tab[ins[2:0]]) pc = lut_tab[ins[2:0]];
            else pc = pc + 8'd1;
            n++;
         end
      end
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_prog(input int max_n, input bit pulse);
      int sc, t;
      bit h;
      start = 1'b1;
      sc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      run_model(sc, max_n, t, h);
      if (pulse) begin
         wait_cyc(sc + 3);
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      if (h) begin
         wait_cyc(sc + t + 4);
         check("done_set", 32'(done), 32'd1);
         wait_cyc(sc + t + 7);
         check("cc_hold", 32'(cycleCount), 32'(t + 2));
      end else begin
         wait_cyc(sc + t + 1);
         reset = 1'b1;
         @(posedge clk); #1;
         reset = 1'b0;
      end
      check("sb_drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int sc;
      for (int i = 0; i < 256; i++) imem[i] = HALT;
      for (int i = 0; i < 8; i++) begin
         lut_tab[i] = 8'd0;
         jf_tab[i]  = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_addr", 32'(instrAddr), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_cc", 32'(cycleCount), 32'd0);
      check("rst_fields", 32'({aluOp, regA, regB, lutIndex}), 32'd0);
      check("rst_strobes", 32'({regWrite, memRead, memWrite}), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // ADD r1,r2 then HALT; start pulsed in EXEC is ignored; rerun from DONE clears the count
      imem[0] = 9'b000_001_010;
      imem[1] = HALT;
      run_prog(10, 1'b1);
      run_prog(10, 1'b0);

      // BLQZ idx 5 taken to 0x20, then not taken
      imem[0] = {3'd7, 3'd0, 3'd5};
      imem[8'h20] = HALT;
      lut_tab[5] = 8'h20;
      jf_tab[5] = 1'b1;
      run_prog(10, 1'b0);
      jf_tab[5] = 1'b0;
      run_prog(10, 1'b0);

      // Branch to 0xFF holding MOV, which wraps back to 0 (loops until stopped by reset)
      imem[0] = {3'd7, 3'd2, 3'd3};
      imem[8'hFF] = {3'd4, 3'd5, 3'd6};
      lut_tab[3] = 8'hFF;
      jf_tab[3] = 1'b1;
      run_prog(4, 1'b0);

      // Reset during the write-back of LD r3,r4
      imem[0] = {3'd5, 3'd3, 3'd4};
      imem[1] = HALT;
      start = 1'b1;
      sc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      push_ctrl(sc + 3, 8'd0, imem[0], 1'b0, 1'b1, 1'b0);
      wait_cyc(sc + 4);
      reset = 1'b1;
      #1;
      check("rst_ldwb_strobes", 32'({regWrite, memRead, memWrite}), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      check("post_rst_strobes", 32'({regWrite, memRead, memWrite}), 32'd0);
      check("post_rst_addr", 32'(instrAddr), 32'd0);
      check("post_rst_done", 32'(done), 32'd0);
      check("post_rst_cc", 32'(cycleCount), 32'd0);
      check("post_rst_drain", 32'(exp_q.size()), 32'd0);
      run_prog(10, 1'b0);

      // Random programs with random branch tables
      for (int p = 0; p < 20; p++) begin
         for (int i = 0; i < 256; i++)
            imem[i] = ($urandom_range(0, 11) == 0) ? HALT : 9'($urandom_range(0, 510));
         for (int i = 0; i < 8; i++) begin
            lut_tab[i] = 8'($urandom_range(0, 255));
            jf_tab[i]  = 1'($urandom_range(0, 1));
         end
         run_prog(40, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_decode_ctrl.md
Name: fetch_decode_ctrl

Overview:
- Multi-cycle fetch/decode/control sequencer; the issuing side of the 8-bit ALU interface.
- Fetches 9-bit instructions and drives aluOp, register selects and write/memory strobes to the datapath.
- Consumes the ALU jumpFlag to resolve BLQZ branches through an external branch lookup table (LUT).
- Sequences start-to-halt program execution and reports completion plus a cycle count.

Parameters:
- PC_W, 8, program counter and instruction address width.
- HALT_INSTR, 9'h1FF, instruction encoding that stops execution.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin execution from PC 0; honoured only in IDLE or DONE.
- instrAddr  output  PC_W  instruction memory address; equals PC.
- instr  input  9  instruction memory data; valid one cycle after instrAddr (synchronous read).
- aluOp  output  3  ALU opcode (ADD, XOR, AND, RSL, MOV, LD, ST, BLQZ), taken from IR[8:6].
- regA  output  3  register select A / destination, IR[5:3].
- regB  output  3  register select B / immediate, IR[2:0].
- regWrite  output  1  register file write strobe.
- memRead  output  1  data memory read strobe.
- memWrite  output  1  data memory write strobe.
- jumpFlag  input  1  ALU branch-taken flag; combinational in the same cycle as aluOp.
- lutIndex  output  3  branch LUT index, IR[2:0].
- lutTarget  input  PC_W  branch target returned by the LUT; combinational.
- done  output  1  program halted.
- cycleCount  output  16  cycles from start to halt.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; PC and IR clear to 0; cycleCount clears to 0.
  - done = 0; aluOp, regA, regB and lutIndex read 0; all strobes are 0.
  - Reset mid-instruction aborts it; no strobe is asserted in the reset cycle or the cycle after.
- States: IDLE, FETCH, DECODE, EXEC, LDWB, DONE.
- IDLE / DONE:
  - start=1 sets PC to 0, clears cycleCount and done, and goes to FETCH.
  - Otherwise the block holds its state.
- FETCH: instrAddr = PC is presented; go to DECODE.
- DECODE:
  - IR <= instr.
  - If instr == HALT_INSTR, go to DONE with done=1 from the next cycle; no strobes are asserted.
  - Otherwise go to EXEC.
- Control outputs are combinational from state and IR.
  - aluOp, regA, regB and lutIndex reflect IR only in EXEC and LDWB; they read 0 in all other states.
- EXEC (one cycle):
  - ADD/XOR/AND/RSL/MOV: regWrite=1; PC <= PC+1; go to FETCH.
  - LD: memRead=1; go to LDWB.
  - ST: memWrite=1; PC <= PC+1; go to FETCH.
  - BLQZ: no strobes; jumpFlag is sampled this cycle. PC <= lutTarget if jumpFlag=1, else PC+1; go to FETCH.
- LDWB: regWrite=1 (loaded data is written back); aluOp stays LD; PC <= PC+1; go to FETCH.
- Latency:
  - ALU/ST/BLQZ instructions: 3 cycles.
  - LD: 4 cycles.
  - HALT: 2 cycles from FETCH to done.
- PC increment wraps modulo 2^PC_W (PC = 2^PC_W - 1 → 0).
- jumpFlag is ignored outside EXEC with BLQZ. A branch to the current PC is legal and loops.
- start is ignored in FETCH, DECODE, EXEC and LDWB.
- start and HALT detection never coincide, since start is not honoured in DECODE.
- cycleCount:
  - Increments every cycle the state is not IDLE or DONE.
  - Saturates at 16'hFFFF.
  - Holds its value in DONE until the next start.
- At most one of regWrite, memRead and memWrite is high in any cycle.

Test Plan:
- Reset then start; imem[0]=ADD r1,r2 (9'b000_001_010), imem[1]=HALT → regWrite=1 with regA=1, regB=2 in cycle 3; done=1; cycleCount=5.
- LD r3,r4 at PC 0 → memRead=1 in EXEC, regWrite=1 in LDWB with regA=3, no regWrite in EXEC; PC becomes 1 after 4 cycles.
- BLQZ with lutIndex=5, lutTarget=8'h20:
  - jumpFlag=1 → next instrAddr=8'h20.
  - jumpFlag=0 → next instrAddr=PC+1.
- PC=8'hFF holding MOV → next instrAddr=8'h00 (wrap).
- Assert reset during the LDWB of an LD → no regWrite that cycle, state IDLE, PC=0, done=0; start after reset re-fetches from address 0.
- start pulsed during EXEC → ignored, program unaffected. start in DONE → restart from PC 0 with cycleCount cleared to 0.
